// File: rtl/mdu_seq.sv
// rtl/mdu_seq.sv - RV32M multi-cycle multiply/divide sequencer (shift-add multiply, restoring divide)
// Optional build macro MDU_FAST_ZERO_EN: zero-operand operations complete straight from accept.
module mdu_seq #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            kill,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            busy
);
   localparam int CW = $clog2(XLEN);
   localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN-1);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
   state_t state, state_nxt;

   logic [2:0]      op_q;
   logic            sa_q, sb_q;
   logic [XLEN:0]   hi_q;
   logic [XLEN-1:0] lo_q, mcand_q, result_q;
   logic [CW-1:0]   cnt_q;

   logic            a_signed, b_signed, sa_in, sb_in;
   logic            div_zero, div_ovf, bypass, accept;
   logic [XLEN-1:0] mag_a, mag_b, byp_result;

   // Operand decode for the accept cycle; magnitude of INT_MIN stays exact as an unsigned value.
   always_comb begin
      a_signed   = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
      b_signed   = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
      sa_in      = a_signed & a[XLEN-1];
      sb_in      = b_signed & b[XLEN-1];
      mag_a      = sa_in ? ({XLEN{1'b0}} - a) : a;
      mag_b      = sb_in ? ({XLEN{1'b0}} - b) : b;
      div_zero   = op[2] && (b == '0);
      div_ovf    = ((op == 3'b100) || (op == 3'b110)) && (a == INT_MIN) && (b == '1);
      bypass     = div_zero || div_ovf;
      byp_result = div_zero ? (op[1] ? a : '1) : (op[1] ? '0 : INT_MIN);
`ifdef MDU_FAST_ZERO_EN
      if (!bypass && ((a == '0) || (!op[2] && (b == '0)))) begin
         bypass     = 1'b1;
         byp_result = '0;
      end
`endif
   end

   logic [XLEN:0]     shifted, alu_x, alu_y, alu_s;
   logic [2*XLEN-1:0] prod, prod_fix;
   logic [XLEN-1:0]   quot_fix, rem_fix, fix_result;

   // One shared 33-bit adder: add multiplicand for multiply, trial-subtract divisor for divide.
   always_comb begin
      shifted  = {hi_q[XLEN-1:0], lo_q[XLEN-1]};
      alu_x    = op_q[2] ? shifted : hi_q;
      alu_y    = op_q[2] ? ~{1'b0, mcand_q} : (lo_q[0] ? {1'b0, mcand_q} : '0);
      alu_s    = alu_x + alu_y + {{XLEN{1'b0}}, op_q[2]};
      prod     = {hi_q[XLEN-1:0], lo_q};
      prod_fix = (sa_q ^ sb_q) ? ({(2*XLEN){1'b0}} - prod) : prod;
      quot_fix = (sa_q ^ sb_q) ? ({XLEN{1'b0}} - lo_q) : lo_q;
      rem_fix  = sa_q ? ({XLEN{1'b0}} - hi_q[XLEN-1:0]) : hi_q[XLEN-1:0];
      if (op_q[2])
         fix_result = op_q[1] ? rem_fix : quot_fix;
      else
         fix_result = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      in_ready  = (state == IDLE);
      busy      = (state != IDLE);
      out_valid = (state == DONE) && !kill;
      result    = result_q;
      case (state)
         IDLE: if (in_valid && !kill) begin
            accept    = 1'b1;
            state_nxt = bypass ? DONE : CALC;
         end
         CALC: begin
            if (kill)                    state_nxt = IDLE;
            else if (cnt_q == CNT_LAST)  state_nxt = FIX;
         end
         FIX:  state_nxt = kill ? IDLE : DONE;
         DONE: if (kill || out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q     <= '0;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         mcand_q  <= '0;
         result_q <= '0;
         cnt_q    <= '0;
      end else if (accept) begin
         op_q    <= op;
         sa_q    <= sa_in;
         sb_q    <= sb_in;
         hi_q    <= '0;
         lo_q    <= mag_a;
         mcand_q <= mag_b;
         cnt_q   <= '0;
         if (bypass) result_q <= byp_result;
      end else if (state == CALC) begin
         cnt_q <= cnt_q + CW'(1);
         if (op_q[2]) begin
            // Non-negative difference means the divisor fits: keep it and shift in a 1.
            if (!alu_s[XLEN]) begin
               hi_q <= alu_s;
               lo_q <= {lo_q[XLEN-2:0], 1'b1};
            end else begin
               hi_q <= shifted;
               lo_q <= {lo_q[XLEN-2:0], 1'b0};
            end
         end else begin
            hi_q <= {1'b0, alu_s[XLEN:1]};
            lo_q <= {alu_s[0], lo_q[XLEN-1:1]};
         end
      end else if (state == FIX) begin
         result_q <= fix_result;
      end
   end
endmodule

// File: tb/tb_mdu_seq.sv
// tb/tb_mdu_seq.sv - self-checking bench for mdu_seq against an arithmetic reference model
// Honours MDU_FAST_ZERO_EN for expected latency of zero-operand operations.
module tb_mdu_seq;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        kill = 1'b0;
   logic        out_ready = 1'b1;
   logic [2:0]  op = 3'd0;
   logic [31:0] a = 32'd0;
   logic [31:0] b = 32'd0;
   logic        in_ready, out_valid, busy;
   logic [31:0] result;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mdu_seq #(.XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b), .kill(kill), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .busy(busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      logic signed [63:0] sx, sy, ux, uy, p;
      logic ovf;
      sx  = {{32{x[31]}}, x};
      sy  = {{32{y[31]}}, y};
      ux  = {32'd0, x};
      uy  = {32'd0, y};
      ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
      p   = 64'sd0;
      case (o)
         3'd0: begin p = ux * uy; return p[31:0];  end
         3'd1: begin p = sx * sy; return p[63:32]; end
         3'd2: begin p = sx * uy; return p[63:32]; end
         3'd3: begin p = ux * uy; return p[63:32]; end
         3'd4: begin
            if (y == 0) return 32'hFFFF_FFFF;
            if (ovf) return 32'h8000_0000;
            p = sx / sy; return p[31:0];
         end
         3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
         3'd6: begin
            if (y == 0) return x;
            if (ovf) return 32'd0;
            p = sx % sy; return p[31:0];
         end
         default: return (y == 0) ? x : x % y;
      endcase
   endfunction

   function automatic int ref_lat(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      if (o[2] && y == 0) return 1;
      if ((o == 3'd4 || o == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
`ifdef MDU_FAST_ZERO_EN
      if (!o[2] && (x == 0 || y == 0)) return 1;
      if (o[2] && x == 0) return 1;
`endif
      return 34;
   endfunction

   // Issue one op, measure cycles to out_valid, optionally stall the consumer, then hand shake.
   task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y, input int stall);
      int lat;
      logic [31:0] res;
      @(negedge clk);
      check({tag, ":in_ready_idle"}, 32'(in_ready), 32'd1);
      op = o; a = x; b = y; in_valid = 1'b1; out_ready = (stall == 0);
      @(negedge clk);
      in_valid = 1'b0;
      op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      res = result;
      check({tag, ":latency"}, 32'(lat), 32'(ref_lat(o, x, y)));
      check({tag, ":result"}, res, ref_res(o, x, y));
      for (int i = 0; i < stall; i++) begin
         check({tag, ":hold_result"}, result, res);
         check({tag, ":hold_valid"}, 32'(out_valid), 32'd1);
         check({tag, ":hold_in_ready"}, 32'(in_ready), 32'd0);
         check({tag, ":hold_busy"}, 32'(busy), 32'd1);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check({tag, ":in_ready_after"}, 32'(in_ready), 32'd1);
      check({tag, ":valid_after"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      logic        seen;
      logic [2:0]  ro;
      logic [31:0] ra, rb;

      repeat (2) @(negedge clk);
      check("reset:in_ready", 32'(in_ready), 32'd1);
      check("reset:out_valid", 32'(out_valid), 32'd0);
      check("reset:busy", 32'(busy), 32'd0);
      check("reset:result", result, 32'd0);
      rst_n = 1'b1;

      run_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFA, 0);
      check("mul:exact", result, 32'hFFFF_FFD6);
      run_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 0);
      run_op("mulhu", 3'd3, 32'h8000_0000, 32'h8000_0000, 0);
      run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      run_op("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 0);
      run_op("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 0);
      run_op("divu", 3'd5, 32'hFFFF_FFFF, 32'd16, 0);
      run_op("remu", 3'd7, 32'hFFFF_FFFF, 32'd16, 0);
      run_op("divu_by0", 3'd5, 32'd123, 32'd0, 0);
      run_op("rem_by0", 3'd6, 32'd123, 32'd0, 0);
      run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_op("backpressure", 3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5);
      run_op("mul_zero", 3'd0, 32'd0, 32'd9, 0);
      run_op("div_zero_a", 3'd4, 32'd0, 32'd5, 0);

      // kill while IDLE wins over in_valid
      @(negedge clk);
      op = 3'd0; a = 32'd3; b = 32'd5; in_valid = 1'b1; kill = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; kill = 1'b0;
      check("kill_idle:busy", 32'(busy), 32'd0);

      // kill in cycle 10 of a divide
      op = 3'd4; a = 32'd1000; b = 32'd7; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (9) @(negedge clk);
      check("kill_calc:busy_before", 32'(busy), 32'd1);
      kill = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      check("kill_calc:busy", 32'(busy), 32'd0);
      check("kill_calc:in_ready", 32'(in_ready), 32'd1);
      seen = 1'b0;
      repeat (40) begin
         if (out_valid) seen = 1'b1;
         @(negedge clk);
      end
      check("kill_calc:no_valid", 32'(seen), 32'd0);
      run_op("after_kill", 3'd0, 32'd3, 32'd5, 0);

      // asynchronous reset mid-CALC
      @(negedge clk);
      op = 3'd0; a = 32'd11; b = 32'd13; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("async_rst:in_ready", 32'(in_ready), 32'd1);
      check("async_rst:out_valid", 32'(out_valid), 32'd0);
      check("async_rst:busy", 32'(busy), 32'd0);
      check("async_rst:result", result, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 40; i++) begin
         ro = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 5))
            0: ra = 32'd0;
            1: ra = 32'h8000_0000;
            2: ra = 32'hFFFF_FFFF;
            default: ra = $urandom;
         endcase
         case ($urandom_range(0, 5))
            0: rb = 32'd0;
            1: rb = 32'h8000_0000;
            2: rb = 32'hFFFF_FFFF;
            default: rb = $urandom;
         endcase
         run_op("random", ro, ra, rb, int'($urandom_range(0, 2)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Multi-cycle sequencer for RV32M multiply/divide, sitting beside the single-cycle ALU in the execute stage.
- Accepts one operation via a valid/ready handshake and runs 32 iterations over an internal 33-bit add/subtract datapath (shift-add multiply, restoring divide).
- Holds the result under output back-pressure.
- Execute stage stalls on busy; kill aborts on pipeline flush.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN; counter width is clog2(XLEN).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation request
- in_ready  output  1  block can accept; high only in IDLE
- op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- a  input  XLEN  rs1 operand
- b  input  XLEN  rs2 operand
- kill  input  1  synchronous abort (pipeline flush)
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- result  output  XLEN  result
- busy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-low (rst_n).
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, result=0, counter=0.
- FSM states: IDLE, CALC, FIX, DONE.
- Accept: occurs when in_valid&&in_ready in IDLE; this is cycle 0.
  - Latches op, magnitudes |a| and |b|, and sign flags.
  - Signed for MULH, DIV and REM (both operands); MULHSU treats a as signed, b as unsigned; all others unsigned.
  - Counter cleared; next state CALC.
- CALC: one iteration per cycle for 32 cycles (cycles 1..32). On counter==XLEN-1, next state is FIX.
  - Multiply: if product LSB is set, add multiplicand into the upper half; shift the 64-bit product right by one.
  - Divide: shift remainder:quotient left by one; trial subtract divisor; if non-negative, keep the difference and set quotient LSB.
- FIX (cycle 33): applies sign correction, registers result, next state DONE.
  - Multiply: negate the 64-bit product when operand signs differ. MUL returns low word; MULH/MULHSU/MULHU return high word.
  - Divide: quotient negated if sa^sb (DIV); remainder takes the dividend sign (REM).
- DONE (cycle 34 onward): out_valid=1; result held stable until out_valid&&out_ready, then IDLE. in_ready rises the cycle after the handshake; there is no same-cycle accept.
- Divide by zero (DIV/DIVU/REM/REMU with b==0): bypasses CALC and goes from accept to DONE; out_valid in cycle 1.
  - Quotient = all ones; remainder = a.
- Signed overflow (DIV/REM with a=0x80000000, b=0xFFFFFFFF): same bypass, out_valid in cycle 1.
  - DIV = 0x80000000; REM = 0.
- Magnitude of 0x80000000 is 0x80000000 unsigned; the 33-bit datapath prevents loss.
- kill:
  - In CALC, FIX or DONE: next state IDLE, out_valid=0, result is not delivered.
  - In IDLE: kill blocks acceptance that cycle; kill wins over in_valid.
- Inputs a, b and op are ignored outside the accept cycle.
- rst_n low at any time: immediately returns to the reset values above.

Optional Feature:
- Macro: MDU_FAST_ZERO_EN.
- Defined:
  - Multiply with a==0 or b==0 goes from accept directly to DONE with result 0; out_valid in cycle 1.
  - Divide/remainder with a==0 and b!=0 does the same with result 0.
- Undefined: these cases take the full 34-cycle path with an identical result value.
- Divide-by-zero and overflow bypasses are present in both builds.

Test Plan:
- MUL: a=7, b=0xFFFFFFFA (-6), out_ready=1 -> out_valid in cycle 34, result=0xFFFFFFD6; in_ready high in cycle 35.
- MULH: a=0x80000000, b=0x80000000 -> result=0x40000000. MULHU with the same operands -> 0x40000000. MULHSU: a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV: a=-7, b=2 -> 0xFFFFFFFD. REM with the same operands -> 0xFFFFFFFF. DIVU: a=0xFFFFFFFF, b=16 -> 0x0FFFFFFF. REMU with the same operands -> 0xF.
- Special cases:
  - DIVU a=123, b=0 -> out_valid in cycle 1, result 0xFFFFFFFF.
  - REM a=123, b=0 -> 123.
  - DIV a=0x80000000, b=-1 -> 0x80000000 in cycle 1.
- Back-pressure: hold out_ready=0 for 5 cycles after out_valid -> result stable, in_ready=0, busy=1. On out_ready=1 the handshake completes and in_ready rises next cycle.
- Abort and reset:
  - kill in cycle 10 of DIV -> IDLE in cycle 11, out_valid never asserts; a following MUL 3×5 returns 15.
  - rst_n low mid-CALC -> all outputs return to reset values asynchronously.
  - With MDU_FAST_ZERO_EN, MUL a=0, b=9 -> result 0 in cycle 1.
